// File: rtl/conv_line_buf_ctrl.sv
// Line-buffer sequencer for a KSIZE x KSIZE convolution window: drives the
// enables of KSIZE-1 cascaded row FIFOs, flags valid window columns, drains at end of frame.
module conv_line_buf_ctrl #(
  parameter int IMG_W = 60,
  parameter int IMG_H = 60,
  parameter int KSIZE = 3,
  parameter int CW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [KSIZE-2:0] fifo_wr_en,
  output logic [KSIZE-2:0] fifo_rd_en,
  input  logic [KSIZE-2:0] fifo_empty,
  input  logic [KSIZE-2:0] fifo_full,
  output logic             win_valid,
  output logic             win_last,
  output logic [CW-1:0]    row,
  output logic [CW-1:0]    col,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int NF = KSIZE - 1;

  typedef enum logic [2:0] {IDLE, PRIME, STREAM, FLUSH, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   fcnt;
  logic [NF-1:0]   wr_dly;
  logic [NF-1:0]   rd_vec;
  logic            accept;
  logic            col_last;
  logic            row_last;
  logic            err_now;

  assign busy      = (state != IDLE);
  assign pix_ready = ((state == PRIME) || (state == STREAM)) && !stall;
  assign accept    = pix_valid && pix_ready;
  assign col_last  = (col == CW'(IMG_W - 1));
  assign row_last  = (row == CW'(IMG_H - 1));

  // FIFO k only holds a full row once row k+1 is reached.
  always_comb begin
    rd_vec = '0;
    for (int unsigned k = 0; k < NF; k++)
      rd_vec[k] = accept && (row >= CW'(k + 1));
  end

  assign fifo_rd_en = (state == FLUSH) ? '1 : rd_vec;
  // wr_dly[0] stays zero; bit 0 is fed straight from the pixel stream.
  assign fifo_wr_en = wr_dly | NF'(accept);

  assign err_now = (|(fifo_wr_en & fifo_full))
                || ((state != FLUSH) && (|(fifo_rd_en & fifo_empty)))
                || ((state == DONE) && !(&fifo_empty));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      fcnt      <= '0;
      wr_dly    <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (!stall) begin
      // Downstream FIFO write trails the upstream read by the 1-cycle data_out latency.
      wr_dly <= '0;
      for (int unsigned k = 1; k < NF; k++)
        wr_dly[k] <= rd_vec[k-1];
      win_valid <= accept && (row >= CW'(NF)) && (col >= CW'(KSIZE - 1));
      win_last  <= accept && row_last && col_last;
      done      <= 1'b0;
      err       <= err || err_now;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row + CW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      case (state)
        IDLE:   if (start) state <= PRIME;
        PRIME:  if (accept && col_last && (row == CW'(NF - 1))) state <= STREAM;
        STREAM: if (accept && col_last && row_last) begin
                  state <= FLUSH;
                  fcnt  <= '0;
                end
        FLUSH:  if (fcnt == CW'(IMG_W - 1)) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  fcnt <= fcnt + CW'(1);
                end
        DONE:   begin
                  state <= IDLE;
                  row   <= '0;
                  col   <= '0;
                end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_line_buf_ctrl.sv
// Randomized bench for conv_line_buf_ctrl against a pixel-count reference model
// with behavioural FIFO occupancy models driving empty/full.
module tb_conv_line_buf_ctrl;

  localparam int W     = 4;
  localparam int H     = 4;
  localparam int K     = 3;
  localparam int NF    = K - 1;
  localparam int CW    = 8;
  localparam int DEPTH = W + 1;

  logic          clk = 1'b0;
  logic          rst, start, stall, pix_valid, pix_ready;
  logic [NF-1:0] fifo_wr_en, fifo_rd_en, fifo_empty, fifo_full;
  logic          win_valid, win_last, busy, done, err;
  logic [CW-1:0] row, col;

  always #5 clk = ~clk;

  conv_line_buf_ctrl #(.IMG_W(W), .IMG_H(H), .KSIZE(K), .CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .win_valid(win_valid),
    .win_last(win_last), .row(row), .col(col), .busy(busy), .done(done), .err(err)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Reference model: phase 0 idle, 1 accepting pixels, 2 draining, 3 done pulse.
  int          phase, n, f;
  bit          m_wv, m_wl, m_err;
  bit [NF-1:0] prev_rd;
  int          occ [NF];
  int          nocc[NF];
  int          win_cnt, last_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    phase = 0; n = 0; f = 0;
    m_wv = 0; m_wl = 0; m_err = 0; prev_rd = '0;
    for (int k = 0; k < NF; k++) begin
      occ[k] = 0; nocc[k] = 0;
    end
    fifo_empty = '1;
    fifo_full  = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_row", row, 0);
    check("rst_col", col, 0);
    check("rst_ready", pix_ready, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_win_last", win_last, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
  endtask

  task automatic step(input bit s_start, input bit pv, input bit stl, input bit ff0);
    bit          exp_ready, acc;
    bit [NF-1:0] exp_rd, exp_wr;
    int          r, c, o;
    @(posedge clk);
    #1;
    for (int k = 0; k < NF; k++) begin
      occ[k]        = nocc[k];
      fifo_empty[k] = (occ[k] == 0);
      fifo_full[k]  = (occ[k] >= DEPTH) || (k == 0 && ff0);
    end
    start = s_start; pix_valid = pv; stall = stl;
    @(negedge clk);
    r = n / W;
    c = n % W;
    exp_ready = (phase == 1) && !stl;
    acc = pv && exp_ready;
    check("busy", busy, phase != 0);
    check("pix_ready", pix_ready, exp_ready);
    check("win_valid", win_valid, m_wv);
    check("win_last", win_last, m_wl);
    check("done", done, phase == 3);
    check("err", err, m_err);
    if (phase <= 1) begin
      check("row", row, r);
      check("col", col, c);
    end
    if (!stl) begin
      for (int k = 0; k < NF; k++) begin
        exp_rd[k] = (phase == 2) ? 1'b1 : (acc && r >= k + 1);
        exp_wr[k] = (k == 0) ? acc : prev_rd[k-1];
      end
      check("wr_en", fifo_wr_en, exp_wr);
      check("rd_en", fifo_rd_en, exp_rd);
      win_cnt  += int'(win_valid);
      last_cnt += int'(win_valid && win_last);
      for (int k = 0; k < NF; k++) begin
        o = occ[k];
        if (fifo_rd_en[k] && o > 0) o--;
        if (fifo_wr_en[k] && occ[k] < DEPTH) o++;
        nocc[k] = o;
      end
      if (ff0 && acc) m_err = 1;
      prev_rd = (phase == 1) ? exp_rd : '0;
      m_wv = acc && r >= NF && c >= K - 1;
      m_wl = acc && n == W * H - 1;
      case (phase)
        0: if (s_start) phase = 1;
        1: if (acc) begin
             n++;
             if (n == W * H) begin phase = 2; f = 0; end
           end
        2: begin f++; if (f == W) phase = 3; end
        default: begin phase = 0; n = 0; end
      endcase
    end
  endtask

  // mode 0: valid held high (start re-pulsed in PRIME), 1: valid toggling,
  // 2: random valid/stall/start, 3: valid high with a 5-cycle stall at row 2 col 1.
  task automatic run_frame(input int mode, input int abort_n, input int err_n);
    int cyc, st_rem;
    bit pv, stl, st, ff0, stalled_once;
    win_cnt = 0; last_cnt = 0; cyc = 0; st_rem = 0; stalled_once = 0;
    step(1'b1, (mode != 2) || ($urandom_range(0, 1) == 1), 1'b0, 1'b0);
    while (phase != 0 && cyc < 2000) begin
      cyc++;
      if (abort_n >= 0 && phase == 1 && n == abort_n) begin
        @(posedge clk);
        #1 rst = 1'b1;
        #1 check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        return;
      end
      pv = 1'b1; stl = 1'b0; st = 1'b0; ff0 = 1'b0;
      case (mode)
        0: st = (phase == 1) && (n < NF * W);
        1: pv = (cyc % 2 == 0);
        2: begin
             pv  = ($urandom_range(0, 3) != 0);
             stl = ($urandom_range(0, 5) == 0);
             st  = ($urandom_range(0, 7) == 0) && (phase != 3);
           end
        default: begin
             if (!stalled_once && phase == 1 && n == 2 * W + 1) begin
               st_rem = 5; stalled_once = 1;
             end
             stl = (st_rem > 0);
             if (st_rem > 0) st_rem--;
           end
      endcase
      if (err_n >= 0 && phase == 1 && n == err_n) ff0 = 1'b1;
      step(st, pv, stl, ff0);
    end
    if (phase != 0) begin
      check("frame_timeout", 0, 1);
      return;
    end
    check("win_count", win_cnt, (H - NF) * (W - K + 1));
    check("win_last_count", last_cnt, 1);
    for (int k = 0; k < NF; k++) check("fifo_drained", nocc[k], 0);
    if (mode == 1) check("toggle_frame_len", cyc >= 2 * W * H, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; pix_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    run_frame(0, -1, -1);
    run_frame(1, -1, -1);
    run_frame(3, -1, -1);
    run_frame(0, 3 * W + 1, -1);
    run_frame(0, -1, -1);
    for (int i = 0; i < 6; i++) run_frame(2, -1, -1);
    run_frame(0, 10, 5);
    run_frame(2, -1, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_line_buf_ctrl.md
Name: conv_line_buf_ctrl

Overview:
- Sequences a cascade of KSIZE-1 synchronous row FIFOs that form the convolution line buffer.
- Accepts a raster pixel stream and drives per-FIFO wr_en/rd_en so each FIFO delays the stream by one image row.
- Flags when a full KxK window column is valid, then drains the FIFOs at end of frame.
- Sits between the input pixel source and the conv kernel's FIFO/PE array. Pixel data never passes through this block; only control, status and counters do.

Parameters:
- IMG_W, 60: pixels per row. Every FIFO depth must be ≥ IMG_W+1, so the default pairs with FIFO depth 61.
- IMG_H, 60: rows per frame.
- KSIZE, 3: kernel height and width. Number of FIFOs NF = KSIZE-1. Legal range 2..8.
- CW, 8: counter width. Must hold both IMG_W-1 and IMG_H-1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle frame start, sampled only in IDLE.
- stall  in  1  global stall; same signal drives the FIFOs' stall.
- pix_valid  in  1  source has a pixel.
- pix_ready  out  1  controller accepts a pixel this cycle.
- fifo_wr_en  out  NF  per-FIFO write enable. Bit 0 is fed by the pixel stream; bit k is fed by FIFO k-1 data_out.
- fifo_rd_en  out  NF  per-FIFO read enable.
- fifo_empty  in  NF  per-FIFO empty.
- fifo_full  in  NF  per-FIFO full.
- win_valid  out  1  FIFO data_outs plus the delayed pixel form a valid window column.
- win_last  out  1  with win_valid, last window column of the frame.
- row  out  CW  row index of the current accepted pixel.
- col  out  CW  column index of the current accepted pixel.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse at end of drain.
- err  out  1  sticky overflow/underflow/residue error.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, row=col=0, all enables 0, win_valid=win_last=done=err=0, pix_ready=0, internal write-delay register=0.
- stall=1 freezes every register, including the FIFO-feed delay register. All outputs hold except pix_ready, which is 0. fifo_*_en are don't-care during stall because the FIFOs also stall.
- accept = pix_valid & pix_ready. pix_ready = (state==PRIME or STREAM) & !stall.
- States:
  - IDLE --start--> PRIME.
  - PRIME: rows 0..NF-1. Transitions to STREAM when an accept occurs at col=IMG_W-1, row=NF-1.
  - STREAM: rows NF..IMG_H-1. Transitions to FLUSH when an accept occurs at row=IMG_H-1, col=IMG_W-1.
  - FLUSH: IMG_W non-stalled cycles, then DONE.
  - DONE: one cycle, done=1, then IDLE.
- start while busy is ignored.
- Counters advance on accept only. col wraps IMG_W-1→0 and increments row at the wrap. row and col clear on entry to IDLE.
- Enable generation (in PRIME and STREAM):
  - fifo_wr_en[0] = accept.
  - fifo_rd_en[k] = accept & (row ≥ k+1).
  - fifo_wr_en[k>0] = fifo_rd_en[k-1] registered by one cycle, because FIFO data_out has 1-cycle latency.
- Enable generation (in FLUSH): fifo_rd_en = all ones, fifo_wr_en = 0. The registered wr_en[k>0] from the final STREAM cycle still fires on the first FLUSH cycle.
- win_valid: registered one cycle after an accept with row ≥ NF and col ≥ KSIZE-1. win_last is registered with the same timing for the final pixel.
- err set conditions:
  - any fifo_wr_en[k] while fifo_full[k]=1.
  - any fifo_rd_en[k] while fifo_empty[k]=1, except during FLUSH.
  - any fifo_empty[k]=0 in DONE.
- err clears only on rst.
- Simultaneous accept and the transition condition: the accepted pixel is counted and enables are issued before the transition.

Test Plan:
- IMG_W=4, IMG_H=4, KSIZE=3, pix_valid held 1, start pulse:
  - 16 accepts in 16 cycles; exactly 4 win_valid pulses, at accepts (2,2), (2,3), (3,2), (3,3); win_last with the 4th.
  - FLUSH lasts 4 cycles; done pulses once; all fifo_empty=1; err=0.
- Same configuration, pix_valid toggling 1/0 every cycle:
  - identical enable sequence compressed to accept cycles; win_valid count = 4; done after 32+ cycles.
- stall=1 for 5 cycles mid-STREAM (row=2, col=1):
  - row, col, state and all outputs hold; pix_ready=0; resuming gives the same win_valid sequence as the unstalled run.
- Force fifo_full[0]=1 while wr_en[0] is asserted:
  - err rises the next cycle and stays 1 until rst.
- Assert rst for one cycle during STREAM (row=3, col=1):
  - immediate IDLE, row=col=0, enables 0, err=0; a new start runs a clean frame.
- start pulse while busy=1 (PRIME):
  - ignored; row and col continue uninterrupted.
